// File: rtl/frame_trigger_matcher.sv
// Observes a framed beat stream and fires a stretched trigger when a frame's
// leading words match a runtime-programmed, per-bit masked pattern.
module frame_trigger_matcher #(
    parameter int DATA_WIDTH     = 32,
    parameter int PATTERN_WORDS  = 8,
    parameter int TRIGGER_CYCLES = 10,
    parameter bit ARM_ON_RESET   = 1'b1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [DATA_WIDTH-1:0]              InData,
    input  logic                               InValid,
    input  logic                               InLast,
    input  logic                               CfgWe,
    input  logic [$clog2(PATTERN_WORDS)-1:0]   CfgAddr,
    input  logic [DATA_WIDTH-1:0]              CfgData,
    input  logic [DATA_WIDTH-1:0]              CfgMask,
    input  logic [$clog2(PATTERN_WORDS+1)-1:0] CfgLen,
    input  logic                               OneShot,
    input  logic                               Arm,
    output logic                               Trigger,
    output logic                               Armed,
    output logic [15:0]                        MatchCount
);

    localparam int AW = $clog2(PATTERN_WORDS);
    localparam int IW = AW + 1;
    localparam int LW = $clog2(PATTERN_WORDS + 1);
    localparam int CW = $clog2(TRIGGER_CYCLES + 1);

    localparam logic [0:0] S_COMPARE = 1'b0;
    localparam logic [0:0] S_DISCARD = 1'b1;

    logic [DATA_WIDTH-1:0] pattern_q [PATTERN_WORDS];
    logic [DATA_WIDTH-1:0] mask_q    [PATTERN_WORDS];

    logic [0:0]    state_q, state_d;
    logic [IW-1:0] index_q, index_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          armed_q, armed_d;
    logic [15:0]   count_q, count_d;

    logic                  addr_ok;
    logic [LW-1:0]         eff_len;
    logic                  idx_ok;
    logic [DATA_WIDTH-1:0] cur_pat;
    logic [DATA_WIDTH-1:0] cur_mask;
    logic                  word_match;
    logic                  at_last_word;
    logic                  hit;
    logic                  fire;

    // Range checks collapse away when the field width exactly fits the depth.
    if ((2 ** AW) == PATTERN_WORDS) begin : g_addr_full
        assign addr_ok = 1'b1;
    end else begin : g_addr_chk
        assign addr_ok = CfgAddr < AW'(PATTERN_WORDS);
    end

    if (((2 ** LW) - 1) == PATTERN_WORDS) begin : g_len_full
        assign eff_len = CfgLen;
    end else begin : g_len_clip
        assign eff_len = (CfgLen > LW'(PATTERN_WORDS))
                       ? LW'(PATTERN_WORDS) : CfgLen;
    end

    assign idx_ok   = index_q < IW'(PATTERN_WORDS);
    assign cur_pat  = pattern_q[index_q[AW-1:0]];
    assign cur_mask = mask_q[index_q[AW-1:0]];

    assign word_match = idx_ok &&
        (((InData ^ cur_pat) & cur_mask) == '0);

    assign at_last_word = (index_q + IW'(1)) == IW'(eff_len);

    assign hit = InValid && (state_q == S_COMPARE) &&
                 (eff_len != '0) && word_match && at_last_word;

    assign fire = hit && armed_q;

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        if (InValid) begin
            if (InLast) begin
                state_d = S_COMPARE;
                index_d = '0;
            end else if (state_q == S_COMPARE) begin
                if ((eff_len == '0) || !word_match || at_last_word) begin
                    state_d = S_DISCARD;
                end else begin
                    index_d = index_q + IW'(1);
                end
            end
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (fire) begin
            cnt_d = CW'(TRIGGER_CYCLES);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // Arm is applied last so it wins over a one-shot clear.
    always_comb begin
        armed_d = armed_q;
        if (fire && OneShot) begin
            armed_d = 1'b0;
        end
        if (Arm) begin
            armed_d = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        if (hit && (count_q != 16'hFFFF)) begin
            count_d = count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_COMPARE;
            index_q <= '0;
            cnt_q   <= '0;
            armed_q <= ARM_ON_RESET;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PATTERN_WORDS; i++) begin
                pattern_q[i] <= '0;
                mask_q[i]    <= '1;
            end
        end else if (CfgWe && addr_ok) begin
            pattern_q[CfgAddr] <= CfgData;
            mask_q[CfgAddr]    <= CfgMask;
        end
    end

    assign Trigger    = cnt_q != '0;
    assign Armed      = armed_q;
    assign MatchCount = count_q;

endmodule

// File: doc/frame_trigger_matcher.md
Name: frame_trigger_matcher

Overview:
Programmable stream pattern matcher that scans beats of a framed data stream, such as RVVI Ethernet frames, and raises a stretched ILA trigger when the leading words of a frame match a stored pattern.
- Pattern words, per-bit compare masks and compare length are runtime-writable through a config port.
- Supports one-shot and auto-rearm modes, and keeps a saturating hit counter.
- Sits between the RVVI receive stream and the ILA trigger input; it only observes the stream and never stalls it.

Parameters:
DATA_WIDTH, 32, width of stream beat and pattern word
PATTERN_WORDS, 8, depth of pattern/mask storage (maximum compare length)
TRIGGER_CYCLES, 10, cycles Trigger stays high per hit (>=1)
ARM_ON_RESET, 1, value of Armed after reset

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
InData  in  DATA_WIDTH  stream beat data
InValid  in  1  beat valid; every valid cycle is consumed
InLast  in  1  qualifies the final beat of a frame (only meaningful with InValid)
CfgWe  in  1  write pattern/mask entry
CfgAddr  in  $clog2(PATTERN_WORDS)  entry index
CfgData  in  DATA_WIDTH  pattern word
CfgMask  in  DATA_WIDTH  compare mask (1 = bit compared)
CfgLen  in  $clog2(PATTERN_WORDS+1)  words to compare; 0 = disabled
OneShot  in  1  1: clear Armed on a hit; 0: stay armed
Arm  in  1  sets Armed (level-sampled each cycle)
Trigger  out  1  ILA trigger
Armed  out  1  trigger enable status
MatchCount  out  16  hits seen since reset, saturating

Behaviour:
Reset (asynchronous):
- State=COMPARE, Index=0, Trigger=0, pulse counter=0, MatchCount=0, Armed=ARM_ON_RESET.
- Pattern regs=0; mask regs=all ones.
- Reset mid-frame: the next valid beat is treated as word 0 of a new frame.

Config:
- CfgWe writes Pattern[CfgAddr]=CfgData and Mask[CfgAddr]=CfgMask at the clock edge.
- A write with CfgAddr>=PATTERN_WORDS is ignored.
- Comparisons use register contents as they stand before the edge. A write in the same cycle as a compare of that entry uses the old value.
- Effective length L = min(CfgLen, PATTERN_WORDS). CfgLen is sampled each beat.

State machine (two states, Index is a counter of width $clog2(PATTERN_WORDS)+1):
- COMPARE, on a valid beat:
  - Word match = ((InData ^ Pattern[Index]) & Mask[Index]) == 0, evaluated combinationally on the beat itself; no input delay stage.
  - L=0 → treat as mismatch.
  - Mismatch → DISCARD.
  - Match with Index==L-1 → hit; go to DISCARD.
  - Otherwise (match, Index<L-1) → Index+1, stay in COMPARE.
- DISCARD: ignore beats until end of frame.
- InLast on any valid beat overrides the transitions above: next state=COMPARE, Index=0. A hit on the last beat still counts.
- Frame shorter than L → no hit.
- Single-beat frame with L=1 and a match → hit.
- Non-valid cycles change nothing.

Hit effects:
- MatchCount increments by 1 (saturates at 16'hFFFF), regardless of Armed.
- If Armed:
  - Trigger goes high on the next cycle (1-cycle latency from the hit beat) and stays high exactly TRIGGER_CYCLES cycles.
  - A new armed hit while Trigger is high restarts the count, so the pulse extends to TRIGGER_CYCLES cycles after the newest hit.
- If OneShot=1 and Armed, Armed is cleared on the next edge.
- Arm=1 in the same cycle as the clearing hit: the trigger fires and Armed stays 1 (Arm wins).
- Unarmed hit: no trigger.

Test Plan:
1. After reset, with L=2, Pattern[0]=32'h1111_6843 and Pattern[1]=32'h1654_4502 (masks all ones), send frame {1111_6843, 1654_4502, 0, last}. Required response: Trigger high on cycles 3..12 after the second beat's edge offset by 1 (10 cycles exactly), MatchCount=1.
2. Same frame with beat 1=32'h1654_4503 → no Trigger, MatchCount=0. The following correct frame triggers, confirming a clean restart after InLast.
3. Mask[1]=32'hFFFF_FF00 with beat 1=32'h1654_45AA → hit. Send a frame ending after beat 0 with InLast → no hit.
4. OneShot=1: two matching frames → only the first triggers, Armed=0 and MatchCount=2. Pulse Arm, then a third frame → triggers.
5. TRIGGER_CYCLES=10, L=1, matching single-beat frames 4 cycles apart → Trigger held continuously 14 cycles. CfgLen=0 → no hits on any traffic.
6. Assert reset mid-frame after a matching beat 0 → Trigger=0 immediately. The next frame matching from its first beat triggers normally.
